mem_access_stage: RTL and testbench

// - MEM stage of the 5-stage RV64 pipeline, located between the EX/MEM register and the writeback stage.
// - Accepts EX/MEM control and data and issues ld/sd-family accesses to data memory over a req/ready handshake.
// - Aligns and extends load data, then registers the MEM/WB fields consumed by writeback.
// - Stalls upstream while a memory access is outstanding.

---
 rtl/riscv_mem_pkg.sv | 48 ++++
 rtl/mem_load_align.sv | 28 ++
 rtl/mem_access_stage.sv | 196 +++++++++++++++++++
 tb/tb_mem_access_stage.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the MEM stage: funct3 encodings, FSM state type and
// store-side helpers.
package riscv_mem_pkg;

   localparam logic [2:0] LB  = 3'b000;
   localparam logic [2:0] LH  = 3'b001;
   localparam logic [2:0] LW  = 3'b010;
   localparam logic [2:0] LD  = 3'b011;
   localparam logic [2:0] LBU = 3'b100;
   localparam logic [2:0] LHU = 3'b101;
   localparam logic [2:0] LWU = 3'b110;
   localparam logic [2:0] SB  = 3'b000;
   localparam logic [2:0] SH  = 3'b001;
   localparam logic [2:0] SW  = 3'b010;
   localparam logic [2:0] SD  = 3'b011;

   typedef enum logic {
      StIdle   = 1'b0,
      StAccess = 1'b1
   } mem_state_e;

   // Byte enables for a store; funct3[1:0] encodes log2 of the access size.
   function automatic logic [7:0] store_strobe(input logic [2:0] funct3,
                                               input logic [2:0] addr_lo);
      logic [7:0] strobe;
      case (funct3[1:0])
         2'b00:   strobe = 8'h01 << addr_lo;
         2'b01:   strobe = 8'h03 << addr_lo;
         2'b10:   strobe = 8'h0F << addr_lo;
         default: strobe = 8'hFF;
      endcase
      return strobe;
   endfunction

   function automatic logic access_illegal(input logic       is_load,
                                           input logic [2:0] funct3,
                                           input logic [2:0] addr_lo);
      logic misaligned;
      case (funct3[1:0])
         2'b00:   misaligned = 1'b0;
         2'b01:   misaligned = addr_lo[0];
         2'b10:   misaligned = |addr_lo[1:0];
         default: misaligned = |addr_lo;
      endcase
      return misaligned | (is_load ? (funct3 == 3'b111) : funct3[2]);
   endfunction

endpackage

// File: rtl/mem_load_align.sv
// Extracts the addressed lane of a read doubleword and sign/zero-extends it
// according to the load funct3.
module mem_load_align
   import riscv_mem_pkg::*;
(
   input  logic [63:0] rdata,
   input  logic [2:0]  addr_lo,
   input  logic [2:0]  funct3,
   output logic [63:0] result
);

   logic [63:0] shifted;

   always_comb begin
      shifted = rdata >> {addr_lo, 3'b000};
      case (funct3)
         LB:      result = {{56{shifted[7]}}, shifted[7:0]};
         LH:      result = {{48{shifted[15]}}, shifted[15:0]};
         LW:      result = {{32{shifted[31]}}, shifted[31:0]};
         LD:      result = shifted;
         LBU:     result = {56'd0, shifted[7:0]};
         LHU:     result = {48'd0, shifted[15:0]};
         LWU:     result = {32'd0, shifted[31:0]};
         default: result = 64'd0;
      endcase
   end

endmodule

// File: rtl/mem_access_stage.sv
// RV64 MEM stage: issues data-memory accesses over req/ready, stalls upstream
// while an access is outstanding, and registers the MEM/WB fields.
module mem_access_stage
   import riscv_mem_pkg::*;
#(
   parameter int unsigned XLEN    = 64,
   parameter int unsigned DMEM_AW = 64
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               ex_mem_valid,
   input  logic               ex_mem_MemRead,
   input  logic               ex_mem_MemWrite,
   input  logic               ex_mem_MemtoReg,
   input  logic               ex_mem_RegWrite,
   input  logic [4:0]         ex_mem_rd,
   input  logic [2:0]         ex_mem_funct3,
   input  logic [XLEN-1:0]    ex_mem_alu_result,
   input  logic [XLEN-1:0]    ex_mem_write_data,
   output logic               dmem_req,
   output logic               dmem_we,
   output logic [DMEM_AW-1:0] dmem_addr,
   output logic [XLEN-1:0]    dmem_wdata,
   output logic [7:0]         dmem_wstrb,
   input  logic               dmem_ready,
   input  logic [XLEN-1:0]    dmem_rdata,
   output logic               mem_stall,
   output logic               mem_fault,
   output logic               mem_wb_valid,
   output logic               mem_wb_MemtoReg,
   output logic               mem_wb_RegWrite,
   output logic [4:0]         mem_wb_rd,
   output logic [XLEN-1:0]    mem_wb_alu_result,
   output logic [XLEN-1:0]    mem_wb_mem_data
);

   mem_state_e state_q, state_d;

   logic            req_we_q, req_we_d;
   logic [XLEN-1:0] req_alu_q, req_alu_d;
   logic [XLEN-1:0] req_wdata_q, req_wdata_d;
   logic [7:0]      req_wstrb_q, req_wstrb_d;
   logic [2:0]      req_funct3_q, req_funct3_d;
   logic [4:0]      req_rd_q, req_rd_d;
   logic            req_regwrite_q, req_regwrite_d;
   logic            req_memtoreg_q, req_memtoreg_d;
   logic            fault_q, fault_d;

   logic            wb_valid_q, wb_valid_d;
   logic            wb_memtoreg_q, wb_memtoreg_d;
   logic            wb_regwrite_q, wb_regwrite_d;
   logic [4:0]      wb_rd_q, wb_rd_d;
   logic [XLEN-1:0] wb_alu_q, wb_alu_d;
   logic [XLEN-1:0] wb_data_q, wb_data_d;

   logic            is_mem;
   logic            is_load;
   logic            illegal;
   logic [2:0]      addr_lo;
   logic [XLEN-1:0] size_mask;
   logic [XLEN-1:0] wdata_lane;
   logic [XLEN-1:0] load_data;

   mem_load_align u_load_align (
      .rdata   (dmem_rdata),
      .addr_lo (req_alu_q[2:0]),
      .funct3  (req_funct3_q),
      .result  (load_data)
   );

   always_comb begin
      is_mem  = ex_mem_MemRead | ex_mem_MemWrite;
      // A load with MemWrite also set is still a load.
      is_load = ex_mem_MemRead;
      addr_lo = ex_mem_alu_result[2:0];
      illegal = access_illegal(is_load, ex_mem_funct3, addr_lo);
      case (ex_mem_funct3[1:0])
         2'b00:   size_mask = 64'h0000_0000_0000_00FF;
         2'b01:   size_mask = 64'h0000_0000_0000_FFFF;
         2'b10:   size_mask = 64'h0000_0000_FFFF_FFFF;
         default: size_mask = 64'hFFFF_FFFF_FFFF_FFFF;
      endcase
      wdata_lane = (ex_mem_write_data & size_mask) << {addr_lo, 3'b000};
   end

   always_comb begin
      state_d        = state_q;
      req_we_d       = req_we_q;
      req_alu_d      = req_alu_q;
      req_wdata_d    = req_wdata_q;
      req_wstrb_d    = req_wstrb_q;
      req_funct3_d   = req_funct3_q;
      req_rd_d       = req_rd_q;
      req_regwrite_d = req_regwrite_q;
      req_memtoreg_d = req_memtoreg_q;
      fault_d        = 1'b0;
      // MEM/WB defaults to a bubble.
      wb_valid_d     = 1'b0;
      wb_memtoreg_d  = 1'b0;
      wb_regwrite_d  = 1'b0;
      wb_rd_d        = 5'd0;
      wb_alu_d       = '0;
      wb_data_d      = '0;

      case (state_q)
         StIdle: begin
            if (ex_mem_valid) begin
               if (!is_mem) begin
                  wb_valid_d    = 1'b1;
                  wb_memtoreg_d = ex_mem_MemtoReg;
                  wb_regwrite_d = ex_mem_RegWrite;
                  wb_rd_d       = ex_mem_rd;
                  wb_alu_d      = ex_mem_alu_result;
               end else if (illegal) begin
                  fault_d = 1'b1;
               end else begin
                  state_d        = StAccess;
                  req_we_d       = ~is_load;
                  req_alu_d      = ex_mem_alu_result;
                  req_wdata_d    = is_load ? '0 : wdata_lane;
                  req_wstrb_d    = is_load ? 8'h00 : store_strobe(ex_mem_funct3, addr_lo);
                  req_funct3_d   = ex_mem_funct3;
                  req_rd_d       = ex_mem_rd;
                  req_regwrite_d = ex_mem_RegWrite;
                  req_memtoreg_d = ex_mem_MemtoReg;
               end
            end
         end
         StAccess: begin
            if (dmem_ready) begin
               state_d       = StIdle;
               wb_valid_d    = 1'b1;
               wb_memtoreg_d = req_memtoreg_q;
               wb_regwrite_d = req_regwrite_q & ~req_we_q;
               wb_rd_d       = req_rd_q;
               wb_alu_d      = req_alu_q;
               wb_data_d     = req_we_q ? '0 : load_data;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= StIdle;
         req_we_q       <= 1'b0;
         req_alu_q      <= '0;
         req_wdata_q    <= '0;
         req_wstrb_q    <= 8'h00;
         req_funct3_q   <= 3'd0;
         req_rd_q       <= 5'd0;
         req_regwrite_q <= 1'b0;
         req_memtoreg_q <= 1'b0;
         fault_q        <= 1'b0;
         wb_valid_q     <= 1'b0;
         wb_memtoreg_q  <= 1'b0;
         wb_regwrite_q  <= 1'b0;
         wb_rd_q        <= 5'd0;
         wb_alu_q       <= '0;
         wb_data_q      <= '0;
      end else begin
         state_q        <= state_d;
         req_we_q       <= req_we_d;
         req_alu_q      <= req_alu_d;
         req_wdata_q    <= req_wdata_d;
         req_wstrb_q    <= req_wstrb_d;
         req_funct3_q   <= req_funct3_d;
         req_rd_q       <= req_rd_d;
         req_regwrite_q <= req_regwrite_d;
         req_memtoreg_q <= req_memtoreg_d;
         fault_q        <= fault_d;
         wb_valid_q     <= wb_valid_d;
         wb_memtoreg_q  <= wb_memtoreg_d;
         wb_regwrite_q  <= wb_regwrite_d;
         wb_rd_q        <= wb_rd_d;
         wb_alu_q       <= wb_alu_d;
         wb_data_q      <= wb_data_d;
      end
   end

   assign dmem_req          = (state_q == StAccess);
   assign dmem_we           = dmem_req & req_we_q;
   assign dmem_addr         = {req_alu_q[DMEM_AW-1:3], 3'b000};
   assign dmem_wdata        = req_wdata_q;
   assign dmem_wstrb        = dmem_req ? req_wstrb_q : 8'h00;
   assign mem_stall         = dmem_req;
   assign mem_fault         = fault_q;
   assign mem_wb_valid      = wb_valid_q;
   assign mem_wb_MemtoReg   = wb_memtoreg_q;
   assign mem_wb_RegWrite   = wb_regwrite_q & wb_valid_q;
   assign mem_wb_rd         = wb_rd_q;
   assign mem_wb_alu_result = wb_alu_q;
   assign mem_wb_mem_data   = wb_data_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed scenarios plus randomized
// traffic checked against a byte-level behavioural model.
module tb_mem_access_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        ex_mem_valid, ex_mem_MemRead, ex_mem_MemWrite, ex_mem_MemtoReg, ex_mem_RegWrite;
   logic [4:0]  ex_mem_rd;
   logic [2:0]  ex_mem_funct3;
   logic [63:0] ex_mem_alu_result, ex_mem_write_data;
   logic        dmem_req, dmem_we, dmem_ready;
   logic [63:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic [7:0]  dmem_wstrb;
   logic        mem_stall, mem_fault;
   logic        mem_wb_valid, mem_wb_MemtoReg, mem_wb_RegWrite;
   logic [4:0]  mem_wb_rd;
   logic [63:0] mem_wb_alu_result, mem_wb_mem_data;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   mem_access_stage dut (
      .clk               (clk),
      .reset             (reset),
      .ex_mem_valid      (ex_mem_valid),
      .ex_mem_MemRead    (ex_mem_MemRead),
      .ex_mem_MemWrite   (ex_mem_MemWrite),
      .ex_mem_MemtoReg   (ex_mem_MemtoReg),
      .ex_mem_RegWrite   (ex_mem_RegWrite),
      .ex_mem_rd         (ex_mem_rd),
      .ex_mem_funct3     (ex_mem_funct3),
      .ex_mem_alu_result (ex_mem_alu_result),
      .ex_mem_write_data (ex_mem_write_data),
      .dmem_req          (dmem_req),
      .dmem_we           (dmem_we),
      .dmem_addr         (dmem_addr),
      .dmem_wdata        (dmem_wdata),
      .dmem_wstrb        (dmem_wstrb),
      .dmem_ready        (dmem_ready),
      .dmem_rdata        (dmem_rdata),
      .mem_stall         (mem_stall),
      .mem_fault         (mem_fault),
      .mem_wb_valid      (mem_wb_valid),
      .mem_wb_MemtoReg   (mem_wb_MemtoReg),
      .mem_wb_RegWrite   (mem_wb_RegWrite),
      .mem_wb_rd         (mem_wb_rd),
      .mem_wb_alu_result (mem_wb_alu_result),
      .mem_wb_mem_data   (mem_wb_mem_data)
   );

   // ---------------- behavioural model ----------------
   function automatic int nbytes(input logic [2:0] f3);
      return 1 << f3[1:0];
   endfunction

   function automatic logic [63:0] model_load(input logic [63:0] d, input int a,
                                              input logic [2:0] f3);
      logic [63:0] v;
      int n;
      n = nbytes(f3);
      v = 64'd0;
      for (int i = 0; i < n; i++) v[8*i +: 8] = d[8*(a+i) +: 8];
      if (!f3[2] && n < 8 && v[8*n-1])
         for (int b = 8*n; b < 64; b++) v[b] = 1'b1;
      return v;
   endfunction

   function automatic logic [7:0] model_strobe(input int a, input logic [2:0] f3);
      logic [7:0] s;
      s = 8'h00;
      for (int i = 0; i < nbytes(f3); i++) s[a+i] = 1'b1;
      return s;
   endfunction

   function automatic logic [63:0] model_wdata(input logic [63:0] d, input int a,
                                               input logic [2:0] f3);
      logic [63:0] w;
      w = 64'd0;
      for (int i = 0; i < nbytes(f3); i++) w[8*(a+i) +: 8] = d[8*i +: 8];
      return w;
   endfunction

   function automatic bit model_illegal(input bit ld, input logic [2:0] f3, input logic [63:0] a);
      return (int'(a[2:0]) % nbytes(f3) != 0) || (ld && f3 == 3'b111) || (!ld && f3[2]);
   endfunction

   // ---------------- drivers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_bubble();
      ex_mem_valid = 0; ex_mem_MemRead = 0; ex_mem_MemWrite = 0;
      ex_mem_MemtoReg = 0; ex_mem_RegWrite = 0; ex_mem_rd = 0; ex_mem_funct3 = 0;
      ex_mem_alu_result = 0; ex_mem_write_data = 0;
   endtask

   task automatic drive_inst(input logic rd_en, wr_en, m2r, rw, input logic [4:0] rd,
                             input logic [2:0] f3, input logic [63:0] alu, wd);
      ex_mem_valid = 1; ex_mem_MemRead = rd_en; ex_mem_MemWrite = wr_en;
      ex_mem_MemtoReg = m2r; ex_mem_RegWrite = rw; ex_mem_rd = rd; ex_mem_funct3 = f3;
      ex_mem_alu_result = alu; ex_mem_write_data = wd;
   endtask

   // One memory instruction from acceptance to MEM/WB, with `waits` ready-low cycles.
   task automatic test_mem_access(input string name, input logic rd_en, wr_en,
                                  input logic [2:0] f3, input logic [63:0] addr, wd, rdv,
                                  input logic [4:0] rd, input logic rw, m2r, input int waits,
                                  output logic [63:0] got_data, output int stall_cnt);
      bit ld;
      int a;
      logic [63:0] exp_data;
      ld = rd_en;
      a = int'(addr[2:0]);
      got_data = 64'd0;
      stall_cnt = 0;
      drive_inst(rd_en, wr_en, m2r, rw, rd, f3, addr, wd);
      tick();
      if (model_illegal(ld, f3, addr)) begin
         checks++; if (dmem_req !== 1'b0) begin errors++;
            $display("FAIL %s fault_req got %b exp 0", name, dmem_req); end
         checks++; if (mem_fault !== 1'b1) begin errors++;
            $display("FAIL %s fault_pulse got %b exp 1", name, mem_fault); end
         checks++; if (mem_wb_valid !== 1'b0 || mem_wb_RegWrite !== 1'b0) begin errors++;
            $display("FAIL %s fault_wb got v=%b rw=%b exp 0 0", name, mem_wb_valid,
                     mem_wb_RegWrite); end
         drive_bubble();
         tick();
         checks++; if (mem_fault !== 1'b0 || dmem_req !== 1'b0) begin errors++;
            $display("FAIL %s fault_end got fault=%b req=%b exp 0 0", name, mem_fault,
                     dmem_req); end
         return;
      end
      for (int c = 0; c <= waits; c++) begin
         checks++; if (dmem_req !== 1'b1 || mem_wb_valid !== 1'b0) begin errors++;
            $display("FAIL %s req_cycle%0d got req=%b wbv=%b exp 1 0", name, c, dmem_req,
                     mem_wb_valid); end
         checks++; if (dmem_addr !== {addr[63:3], 3'b000}) begin errors++;
            $display("FAIL %s addr got %h exp %h", name, dmem_addr, {addr[63:3], 3'b000}); end
         checks++; if (dmem_we !== logic'(!ld)) begin errors++;
            $display("FAIL %s we got %b exp %b", name, dmem_we, !ld); end
         checks++; if (dmem_wstrb !== (ld ? 8'h00 : model_strobe(a, f3))) begin errors++;
            $display("FAIL %s wstrb got %h exp %h", name, dmem_wstrb,
                     ld ? 8'h00 : model_strobe(a, f3)); end
         if (!ld) begin
            checks++; if (dmem_wdata !== model_wdata(wd, a, f3)) begin errors++;
               $display("FAIL %s wdata got %h exp %h", name, dmem_wdata,
                        model_wdata(wd, a, f3)); end
         end
         if (mem_stall === 1'b1) stall_cnt++;
         if (c == waits) begin
            dmem_ready = 1; dmem_rdata = rdv;
         end else begin
            dmem_ready = 0; dmem_rdata = {$urandom, $urandom};
         end
         tick();
      end
      dmem_ready = 0;
      drive_bubble();
      got_data = mem_wb_mem_data;
      exp_data = ld ? model_load(rdv, a, f3) : 64'd0;
      checks++; if (stall_cnt != waits + 1) begin errors++;
         $display("FAIL %s stall_cycles got %0d exp %0d", name, stall_cnt, waits + 1); end
      checks++; if (mem_wb_valid !== 1'b1 || mem_stall !== 1'b0 || dmem_req !== 1'b0) begin
         errors++; $display("FAIL %s done got v=%b stall=%b req=%b exp 1 0 0", name,
                            mem_wb_valid, mem_stall, dmem_req); end
      checks++; if (mem_wb_RegWrite !== (ld ? rw : 1'b0)) begin errors++;
         $display("FAIL %s wb_regwrite got %b exp %b", name, mem_wb_RegWrite, ld ? rw : 1'b0); end
      checks++; if (mem_wb_rd !== rd || mem_wb_alu_result !== addr || mem_wb_MemtoReg !== m2r)
      begin errors++; $display("FAIL %s wb_fields got rd=%0d alu=%h m2r=%b exp %0d %h %b", name,
                               mem_wb_rd, mem_wb_alu_result, mem_wb_MemtoReg, rd, addr, m2r); end
      checks++; if (mem_wb_mem_data !== exp_data) begin errors++;
         $display("FAIL %s wb_data got %h exp %h", name, mem_wb_mem_data, exp_data); end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      reset = 1;
      drive_inst(0, 0, 0, 1, 5'd3, 3'd0, 64'h55, 64'h0);
      tick();
      tick();
      checks++; if ({dmem_req, dmem_we, mem_stall, mem_fault, dmem_wstrb} !== 12'd0) begin
         errors++; $display("FAIL reset_ctrl got req=%b we=%b stall=%b fault=%b strb=%h exp 0",
                            dmem_req, dmem_we, mem_stall, mem_fault, dmem_wstrb); end
      checks++; if ({mem_wb_valid, mem_wb_MemtoReg, mem_wb_RegWrite, mem_wb_rd} !== 8'd0) begin
         errors++; $display("FAIL reset_wb_ctrl got v=%b m2r=%b rw=%b rd=%0d exp 0", mem_wb_valid,
                            mem_wb_MemtoReg, mem_wb_RegWrite, mem_wb_rd); end
      checks++; if (mem_wb_alu_result !== 64'd0 || mem_wb_mem_data !== 64'd0) begin errors++;
         $display("FAIL reset_wb_data got alu=%h data=%h exp 0 0", mem_wb_alu_result,
                  mem_wb_mem_data); end
      drive_bubble();
      reset = 0;
      tick();
   endtask

   task automatic test_alu_pass();
      drive_inst(0, 0, 0, 1, 5'd5, 3'd0, 64'h1234, 64'h0);
      tick();
      checks++; if (mem_wb_valid !== 1 || mem_wb_rd !== 5'd5 || mem_wb_alu_result !== 64'h1234
                    || mem_stall !== 0 || mem_wb_RegWrite !== 1 || mem_wb_mem_data !== 0) begin
         errors++; $display("FAIL alu_pass got v=%b rd=%0d alu=%h stall=%b rw=%b data=%h",
                            mem_wb_valid, mem_wb_rd, mem_wb_alu_result, mem_stall,
                            mem_wb_RegWrite, mem_wb_mem_data); end
      drive_bubble();
      ex_mem_RegWrite = 1; ex_mem_rd = 5'd9;
      tick();
      checks++; if (mem_wb_valid !== 0 || mem_wb_RegWrite !== 0) begin errors++;
         $display("FAIL bubble got v=%b rw=%b exp 0 0", mem_wb_valid, mem_wb_RegWrite); end
      drive_bubble();
   endtask

   task automatic test_load_byte();
      logic [63:0] got;
      int st;
      test_mem_access("lb", 1, 0, 3'b000, 64'h1003, 64'h0, 64'h0000_0000_8000_0000, 5'd4,
                      1, 1, 0, got, st);
      checks++; if (got !== 64'hFFFF_FFFF_FFFF_FF80) begin errors++;
         $display("FAIL lb_value got %h exp ffffffffffffff80", got); end
      test_mem_access("lbu", 1, 0, 3'b100, 64'h1003, 64'h0, 64'h0000_0000_8000_0000, 5'd4,
                      1, 1, 0, got, st);
      checks++; if (got !== 64'h80) begin errors++;
         $display("FAIL lbu_value got %h exp 80", got); end
   endtask

   task automatic test_store_half();
      logic [63:0] got;
      int st;
      test_mem_access("sh", 0, 1, 3'b001, 64'h2002, 64'h0000_0000_0000_ABCD, 64'h0, 5'd6,
                      1, 0, 3, got, st);
      checks++; if (st != 4) begin errors++;
         $display("FAIL sh_stall_count got %0d exp 4", st); end
   endtask

   task automatic test_fault();
      logic [63:0] got;
      int st;
      test_mem_access("ld_misaligned", 1, 0, 3'b011, 64'h3004, 64'h0, 64'h0, 5'd2, 1, 1, 0,
                      got, st);
      drive_inst(0, 0, 0, 1, 5'd8, 3'd0, 64'hBEEF, 64'h0);
      tick();
      checks++; if (mem_wb_valid !== 1 || mem_wb_rd !== 5'd8 || mem_stall !== 0
                    || mem_wb_alu_result !== 64'hBEEF) begin errors++;
         $display("FAIL after_fault_alu got v=%b rd=%0d stall=%b alu=%h exp 1 8 0 beef",
                  mem_wb_valid, mem_wb_rd, mem_stall, mem_wb_alu_result); end
      drive_bubble();
   endtask

   task automatic test_reset_in_access();
      drive_inst(1, 0, 1, 1, 5'd11, 3'b010, 64'h40, 64'h0);
      tick();
      dmem_ready = 0;
      tick();
      checks++; if (dmem_req !== 1'b1) begin errors++;
         $display("FAIL rst_access_pre got req=%b exp 1", dmem_req); end
      reset = 1; dmem_ready = 1; dmem_rdata = 64'h1111_2222_3333_4444;
      tick();
      checks++; if (dmem_req !== 0 || mem_stall !== 0 || mem_wb_valid !== 0
                    || mem_wb_RegWrite !== 0 || mem_wb_rd !== 0 || mem_wb_mem_data !== 0
                    || mem_wb_alu_result !== 0) begin errors++;
         $display("FAIL rst_access got req=%b stall=%b v=%b rw=%b rd=%0d data=%h alu=%h",
                  dmem_req, mem_stall, mem_wb_valid, mem_wb_RegWrite, mem_wb_rd,
                  mem_wb_mem_data, mem_wb_alu_result); end
      reset = 0;
      drive_bubble();
      tick();
      checks++; if (dmem_req !== 0 || mem_stall !== 0 || mem_wb_valid !== 0) begin errors++;
         $display("FAIL rst_late_ready got req=%b stall=%b v=%b exp 0 0 0", dmem_req,
                  mem_stall, mem_wb_valid); end
      dmem_ready = 0;
   endtask

   task automatic test_back_to_back();
      logic [63:0] rdv;
      rdv = {$urandom, $urandom};
      drive_inst(1, 0, 1, 1, 5'd7, 3'b010, 64'h108, 64'h0);
      tick();
      checks++; if (mem_stall !== 1 || mem_wb_valid !== 0) begin errors++;
         $display("FAIL b2b_stall got stall=%b v=%b exp 1 0", mem_stall, mem_wb_valid); end
      // The add is now held in EX/MEM behind the stall.
      drive_inst(0, 0, 0, 1, 5'd9, 3'd0, 64'h77, 64'h0);
      dmem_ready = 1; dmem_rdata = rdv;
      tick();
      dmem_ready = 0;
      checks++; if (mem_wb_valid !== 1 || mem_wb_rd !== 5'd7 || mem_stall !== 0
                    || mem_wb_mem_data !== model_load(rdv, 0, 3'b010)) begin errors++;
         $display("FAIL b2b_lw got v=%b rd=%0d stall=%b data=%h exp 1 7 0 %h", mem_wb_valid,
                  mem_wb_rd, mem_stall, mem_wb_mem_data, model_load(rdv, 0, 3'b010)); end
      tick();
      drive_bubble();
      checks++; if (mem_wb_valid !== 1 || mem_wb_rd !== 5'd9 || mem_wb_alu_result !== 64'h77
                    || mem_wb_mem_data !== 0) begin errors++;
         $display("FAIL b2b_add got v=%b rd=%0d alu=%h data=%h exp 1 9 77 0", mem_wb_valid,
                  mem_wb_rd, mem_wb_alu_result, mem_wb_mem_data); end
   endtask

   task automatic test_random();
      logic [63:0] got, addr, wd, rdv;
      logic [4:0]  rd;
      logic [2:0]  f3;
      logic        rw, m2r;
      int          st, kind;
      for (int it = 0; it < 60; it++) begin
         kind = $urandom_range(0, 3);
         rd = 5'($urandom); rw = 1'($urandom); m2r = 1'($urandom);
         f3 = 3'($urandom);
         wd = {$urandom, $urandom}; rdv = {$urandom, $urandom};
         addr = {32'd0, $urandom} & ~64'h7;
         // Mostly aligned addresses, with occasional misalignment.
         if ($urandom_range(0, 3) != 0)
            addr[2:0] = 3'($urandom_range(0, 7)) & ~3'(nbytes(f3) - 1);
         else
            addr[2:0] = 3'($urandom);
         if (kind == 0) begin
            drive_inst(0, 0, m2r, rw, rd, f3, addr, wd);
            tick();
            drive_bubble();
            checks++; if (mem_wb_valid !== 1 || mem_wb_rd !== rd || mem_wb_alu_result !== addr
                          || mem_wb_RegWrite !== rw || mem_wb_MemtoReg !== m2r
                          || mem_wb_mem_data !== 0 || mem_stall !== 0) begin errors++;
               $display("FAIL rnd_alu%0d got v=%b rd=%0d alu=%h rw=%b m2r=%b stall=%b", it,
                        mem_wb_valid, mem_wb_rd, mem_wb_alu_result, mem_wb_RegWrite,
                        mem_wb_MemtoReg, mem_stall); end
         end else begin
            test_mem_access($sformatf("rnd%0d_k%0d", it, kind), kind != 2, kind >= 2, f3,
                            addr, wd, rdv, rd, rw, m2r, $urandom_range(0, 2), got, st);
         end
      end
   endtask

   initial begin
      reset = 1; dmem_ready = 0; dmem_rdata = 64'd0;
      drive_bubble();
      test_reset();
      test_alu_pass();
      test_load_byte();
      test_store_half();
      test_fault();
      test_reset_in_access();
      test_back_to_back();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
